// File: rtl/lz_pop_unit.sv
// lz_pop_unit: three-stage pipelined 64-bit leading-zero / population / parity unit.
// Revision: 1.0
`default_nettype none

module lz_pop_unit #(
  parameter int WIDTH  = 64,
  parameter int RES_W  = 7,
  parameter int DEST_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [DEST_W-1:0] i_dest,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [RES_W-1:0]  o_result,
  output logic [DEST_W-1:0] o_dest,
  output logic              o_busy
);

  localparam int NB = WIDTH / 8;

  localparam logic [1:0] OP_LZC = 2'b00;
  localparam logic [1:0] OP_POP = 2'b01;
  localparam logic [1:0] OP_PAR = 2'b10;

  function automatic logic [2:0] lz8(input logic [7:0] b);
    logic [2:0] n;
    n = 3'd7;
    for (int i = 0; i < 8; i++)
      if (b[i]) n = 3'(7 - i);
    return n;
  endfunction

  function automatic logic [3:0] pop8(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++)
      n = n + {3'b000, b[i]};
    return n;
  endfunction

  // Byte slices
  logic [NB-1:0]       byte_zbar;
  logic [NB-1:0][2:0]  byte_lz;
  logic [NB-1:0][3:0]  byte_pc;

  for (genvar k = 0; k < NB; k++) begin : g_byte
    assign byte_zbar[k] = |i_data[8*k +: 8];
    assign byte_lz[k]   = lz8(i_data[8*k +: 8]);
    assign byte_pc[k]   = pop8(i_data[8*k +: 8]);
  end

  // Stage 1
  logic                s1_valid;
  logic [1:0]          s1_op;
  logic [DEST_W-1:0]   s1_dest;
  logic [NB-1:0]       s1_zbar;
  logic [NB-1:0][2:0]  s1_lz;
  logic [NB-1:0][3:0]  s1_pc;

  // Stage 2
  logic                s2_valid;
  logic [DEST_W-1:0]   s2_dest;
  logic [RES_W-1:0]    s2_result;

  logic [RES_W-1:0]    lzc_cnt;
  logic [RES_W-1:0]    pop_cnt;
  logic                parity;
  logic [RES_W-1:0]    comb_result;

  // Ascending scan so the most significant non-zero byte determines the count.
  always_comb begin
    lzc_cnt = RES_W'(WIDTH);
    pop_cnt = '0;
    parity  = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (s1_zbar[k]) lzc_cnt = RES_W'(8 * (NB - 1 - k)) + RES_W'(s1_lz[k]);
      pop_cnt = pop_cnt + RES_W'(s1_pc[k]);
      parity  = parity ^ s1_pc[k][0];
    end
  end

  always_comb begin
    comb_result = '0;
    case (s1_op)
      OP_LZC:  comb_result = lzc_cnt;
      OP_POP:  comb_result = pop_cnt;
      OP_PAR:  comb_result = RES_W'(parity);
      default: comb_result = '0;
    endcase
  end

  // A flush kills what is already in flight but never the op issued alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_dest   <= '0;
      s1_zbar   <= '0;
      s1_lz     <= '0;
      s1_pc     <= '0;
      s2_valid  <= 1'b0;
      s2_dest   <= '0;
      s2_result <= '0;
      o_valid   <= 1'b0;
      o_result  <= '0;
      o_dest    <= '0;
    end else begin
      s1_valid <= i_start;
      if (i_start) begin
        s1_op   <= i_op;
        s1_dest <= i_dest;
        s1_zbar <= byte_zbar;
        s1_lz   <= byte_lz;
        s1_pc   <= byte_pc;
      end

      s2_valid <= s1_valid & ~i_flush;
      if (s1_valid && !i_flush) begin
        s2_dest   <= s1_dest;
        s2_result <= comb_result;
      end

      o_valid <= s2_valid & ~i_flush;
      if (s2_valid && !i_flush) begin
        o_dest   <= s2_dest;
        o_result <= s2_result;
      end
    end
  end

  assign o_busy = s1_valid | s2_valid | o_valid;

endmodule

`default_nettype wire

// File: tb/tb_lz_pop_unit.sv
// tb_lz_pop_unit: directed and randomized checks of lz_pop_unit against an arrival-schedule reference model.
// Revision: 1.0
`default_nettype none

module tb_lz_pop_unit;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [1:0]  i_op;
  logic [63:0] i_data;
  logic [2:0]  i_dest;
  logic        i_flush;
  logic        o_valid;
  logic [6:0]  o_result;
  logic [2:0]  o_dest;
  logic        o_busy;

  lz_pop_unit #(.WIDTH(64), .RES_W(7), .DEST_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_data   (i_data),
    .i_dest   (i_dest),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_dest   (o_dest),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Expected results keyed by the cycle in which they must be visible.
  bit         exp_valid [int];
  logic [6:0] exp_res   [int];
  logic [2:0] exp_dest  [int];
  logic [6:0] last_res  = '0;
  logic [2:0] last_dest = '0;

  function automatic logic [6:0] ref_result(input logic [1:0] op, input logic [63:0] d);
    int n;
    case (op)
      2'b00: begin
        n = 0;
        for (int i = 63; i >= 0; i--) begin
          if (d[i]) break;
          n++;
        end
        return 7'(n);
      end
      2'b01:   return 7'($countones(d));
      2'b10:   return {6'b0, ^d};
      default: return 7'd0;
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit ev;
    bit eb;
    ev = exp_valid.exists(cyc);
    eb = exp_valid.exists(cyc) || exp_valid.exists(cyc + 1) || exp_valid.exists(cyc + 2);
    cmp("valid", 64'(o_valid), 64'(ev));
    cmp("busy", 64'(o_busy), 64'(eb));
    if (ev) begin
      last_res  = exp_res[cyc];
      last_dest = exp_dest[cyc];
      exp_valid.delete(cyc);
    end
    cmp("result", 64'(o_result), 64'(last_res));
    cmp("dest", 64'(o_dest), 64'(last_dest));
  endtask

  task automatic run_cycle(input bit start, input logic [1:0] op, input logic [63:0] d,
                           input logic [2:0] dest, input bit flush);
    check_outputs();
    i_start = start;
    i_op    = op;
    i_data  = d;
    i_dest  = dest;
    i_flush = flush;
    if (flush) begin
      exp_valid.delete(cyc + 1);
      exp_valid.delete(cyc + 2);
    end
    if (start) begin
      exp_valid[cyc + 3] = 1'b1;
      exp_res[cyc + 3]   = ref_result(op, d);
      exp_dest[cyc + 3]  = dest;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 2'b00, 64'h0, 3'd0, 1'b0);
  endtask

  initial begin
    logic [63:0] one;
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_op    = 2'b00;
    i_data  = '0;
    i_dest  = '0;
    i_flush = 1'b0;
    one     = 64'd1;
    @(posedge clk);
    @(posedge clk);
    #1;
    cmp("reset_valid", 64'(o_valid), 64'd0);
    cmp("reset_result", 64'(o_result), 64'd0);
    cmp("reset_dest", 64'(o_dest), 64'd0);
    cmp("reset_busy", 64'(o_busy), 64'd0);
    rst_n = 1'b1;

    // LZC sweep, back-to-back
    for (int b = 0; b < 64; b++) run_cycle(1'b1, 2'b00, one << b, 3'(b), 1'b0);
    run_cycle(1'b1, 2'b00, 64'h0, 3'd1, 1'b0);
    run_cycle(1'b1, 2'b00, '1, 3'd2, 1'b0);
    idle(4);

    // POP / PARITY corners
    run_cycle(1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    run_cycle(1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 1'b0);
    run_cycle(1'b1, 2'b01, 64'h8000_0000_0000_0001, 3'd3, 1'b0);
    run_cycle(1'b1, 2'b10, 64'h8000_0000_0000_0001, 3'd4, 1'b0);
    run_cycle(1'b1, 2'b01, 64'h0000_0000_0000_0007, 3'd5, 1'b0);
    run_cycle(1'b1, 2'b10, 64'h0000_0000_0000_0007, 3'd6, 1'b0);
    run_cycle(1'b1, 2'b11, 64'h1234_5678_9ABC_DEF0, 3'd7, 1'b0);
    idle(4);

    // Back-to-back mixed ops, with explicit expected values
    run_cycle(1'b1, 2'b00, 64'h00FF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    run_cycle(1'b1, 2'b01, 64'h0000_0000_0000_000F, 3'd2, 1'b0);
    run_cycle(1'b1, 2'b10, 64'h0000_0000_0000_0001, 3'd3, 1'b0);
    cmp("b2b_lzc", {57'd0, o_valid, o_result}, {57'd0, 1'b1, 7'd8});
    run_cycle(1'b0, 2'b00, 64'h0, 3'd0, 1'b0);
    cmp("b2b_pop", {57'd0, o_valid, o_result}, {57'd0, 1'b1, 7'd4});
    run_cycle(1'b0, 2'b00, 64'h0, 3'd0, 1'b0);
    cmp("b2b_par", {57'd0, o_valid, o_result}, {57'd0, 1'b1, 7'd1});
    idle(3);

    // Flush: only the op issued with the flush survives
    run_cycle(1'b1, 2'b01, 64'hF0F0, 3'd5, 1'b0);
    run_cycle(1'b1, 2'b01, 64'hFF, 3'd6, 1'b0);
    run_cycle(1'b1, 2'b00, 64'h1, 3'd7, 1'b1);
    idle(4);

    // Asynchronous reset with two ops in flight
    run_cycle(1'b1, 2'b01, '1, 3'd3, 1'b0);
    run_cycle(1'b1, 2'b00, 64'h1, 3'd4, 1'b0);
    i_start = 1'b0;
    rst_n   = 1'b0;
    #2;
    cmp("arst_valid", 64'(o_valid), 64'd0);
    cmp("arst_result", 64'(o_result), 64'd0);
    cmp("arst_dest", 64'(o_dest), 64'd0);
    cmp("arst_busy", 64'(o_busy), 64'd0);
    exp_valid.delete();
    last_res  = '0;
    last_dest = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    idle(5);

    // Randomized traffic with occasional flushes and reserved ops
    for (int n = 0; n < 10000; n++) begin
      run_cycle(($urandom_range(3, 0) != 0), 2'($urandom_range(3, 0)),
                {$urandom, $urandom} >> $urandom_range(63, 0),
                3'($urandom_range(7, 0)), ($urandom_range(31, 0) == 0));
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
